// File: rtl/serial.sv
// Frame serialiser: shifts a 4-bit opcode (plus a 10-bit payload for opcode 0)
// out MSB first on a divided bit clock, then idles for a fixed gap.
module serial #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cmd_in,
  input  logic [31:0] data_in,
  output logic        data_out,
  output logic        clock_out,
  output logic        busy,
  output logic        ack_toggle
);

  localparam int unsigned DIV_W   = 17;
  localparam int unsigned FRAME_W = 14;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned GAP_W   = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [BIT_W-1:0]   bits_left;
  logic [FRAME_W-1:0] shift;
  logic               acc_tog;

  logic [3:0] opcode;
  logic [9:0] payload;
  logic       unused_in;

  assign opcode    = cmd_in[4:1];
  assign payload   = data_in[9:0];
  assign unused_in = ^{cmd_in[31:5], data_in[31:10]};

  // Frame sequencer; every output is a register so the far end sees clean edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      bits_left  <= '0;
      shift      <= '0;
      acc_tog    <= 1'b0;
      data_out   <= 1'b0;
      clock_out  <= 1'b0;
      busy       <= 1'b0;
      ack_toggle <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_in[0] != acc_tog) begin
            acc_tog   <= cmd_in[0];
            busy      <= 1'b1;
            div_cnt   <= '0;
            clock_out <= 1'b0;
            data_out  <= opcode[3];
            state     <= LOW;
            // Only opcode 0 carries the payload; shorter frames are left-justified.
            if (opcode == 4'd0) begin
              shift     <= {opcode, payload};
              bits_left <= BIT_W'(14);
            end else begin
              shift     <= {opcode, 10'd0};
              bits_left <= BIT_W'(4);
            end
          end
        end

        LOW: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            clock_out <= 1'b1;
            state     <= HIGH;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        HIGH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            clock_out <= 1'b0;
            if (bits_left > BIT_W'(1)) begin
              shift     <= {shift[FRAME_W-2:0], 1'b0};
              data_out  <= shift[FRAME_W-2];
              bits_left <= bits_left - BIT_W'(1);
              state     <= LOW;
            end else begin
              data_out <= 1'b0;
              gap_cnt  <= '0;
              state    <= GAP;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt    <= '0;
            ack_toggle <= ~ack_toggle;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial.sv
// Directed bench for serial: deserialises clock_out/data_out and checks framing,
// timing, request coalescing and reset behaviour.
module tb_serial;
  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned GAP_CYCLES = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cmd_in = '0;
  logic [31:0] data_in = '0;
  logic        data_out, clock_out, busy, ack_toggle;

  int passed = 0;
  int total  = 0;

  int          cap_rises, cap_busy, cap_wait, cap_min_iv, cap_max_iv, cap_hold_err;
  logic [13:0] cap_bits;
  logic        cap_timeout;

  serial #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clock(clock), .reset(reset), .cmd_in(cmd_in), .data_in(data_in),
    .data_out(data_out), .clock_out(clock_out), .busy(busy), .ack_toggle(ack_toggle)
  );

  always #5 clock = ~clock;

  // Raise a request by flipping cmd_in[0]; upper command bits get junk.
  task automatic kick(input logic [3:0] op, input logic [31:0] d);
    logic [26:0] junk;
    @(negedge clock);
    junk    = 27'($urandom);
    cmd_in  = {junk, op, ~cmd_in[0]};
    data_in = d;
  endtask

  // Watch one frame on the serial pins, sampling at negedges; optional input changes mid-frame.
  task automatic capture(input int chg_at, input logic [31:0] chg_cmd, input logic [31:0] chg_data,
                         input int chg2_at, input logic [31:0] chg2_cmd);
    int   last_rise, iv;
    logic pck, pd;
    cap_rises = 0; cap_bits = '0; cap_busy = 0; cap_wait = 0;
    cap_min_iv = 1000; cap_max_iv = 0; cap_hold_err = 0; cap_timeout = 1'b1;
    pck = clock_out; pd = data_out; last_rise = 0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clock);
      if (busy) cap_busy++;
      else if (cap_busy == 0) cap_wait++;
      if (clock_out && !pck) begin
        if (cap_rises > 0) begin
          iv = cyc - last_rise;
          if (iv < cap_min_iv) cap_min_iv = iv;
          if (iv > cap_max_iv) cap_max_iv = iv;
        end
        last_rise = cyc;
        cap_rises++;
        cap_bits = {cap_bits[12:0], data_out};
      end
      if (clock_out && data_out !== pd) cap_hold_err++;
      pck = clock_out; pd = data_out;
      if (busy && chg_at > 0 && cap_busy == chg_at) begin
        cmd_in = chg_cmd; data_in = chg_data;
      end
      if (busy && chg2_at > 0 && cap_busy == chg2_at) cmd_in = chg2_cmd;
      if (!busy && cap_busy > 0) begin
        cap_timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({data_out, clock_out, busy, ack_toggle} !== 4'b0000) $display("FAIL reset_outputs: got %b expected 0000", {data_out, clock_out, busy, ack_toggle});
    else passed++;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    total++;
    if (busy !== 1'b0) $display("FAIL reset_no_request: busy got %b expected 0", busy);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    int rises;
    logic pck;
    kick(4'd0, 32'h0000_0155);
    rises = 0; pck = clock_out;
    for (int cyc = 0; cyc < 200 && rises < 6; cyc++) begin
      @(negedge clock);
      if (clock_out && !pck) rises++;
      pck = clock_out;
    end
    total++;
    if (rises !== 6) $display("FAIL midframe_rises_before_reset: got %0d expected 6", rises);
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if ({data_out, clock_out, busy, ack_toggle} !== 4'b0000) $display("FAIL midframe_async_reset: got %b expected 0000", {data_out, clock_out, busy, ack_toggle});
    else passed++;
    repeat (3) @(negedge clock);
    // cmd_in[0] is still 1, so release restarts the frame cleanly.
    reset = 1'b1;
    capture(0, '0, '0, 0, '0);
    total++;
    if (cap_timeout || cap_wait != 0) $display("FAIL post_reset_start: timeout %b wait %0d expected 0/0", cap_timeout, cap_wait);
    else passed++;
    total++;
    if (cap_rises != 14 || cap_bits !== 14'h0155) $display("FAIL post_reset_frame: rises %0d bits %h expected 14 / 0155", cap_rises, cap_bits);
    else passed++;
    total++;
    if (ack_toggle !== 1'b1) $display("FAIL post_reset_ack: got %b expected 1", ack_toggle);
    else passed++;
  endtask

  task automatic test_frame_op0();
    logic ack0;
    ack0 = ack_toggle;
    kick(4'd0, 32'hABCD_E2B5);
    capture(0, '0, '0, 0, '0);
    total++;
    if (cap_timeout || cap_bits !== 14'b0000_1010110101) $display("FAIL op0_bits: got %b expected 00001010110101 (timeout %b)", cap_bits, cap_timeout);
    else passed++;
    total++;
    if (cap_rises != 14) $display("FAIL op0_rises: got %0d expected 14", cap_rises);
    else passed++;
    total++;
    if (cap_min_iv != 4 || cap_max_iv != 4) $display("FAIL op0_rise_spacing: got %0d..%0d expected 4..4", cap_min_iv, cap_max_iv);
    else passed++;
    total++;
    if (cap_busy != 60) $display("FAIL op0_busy_len: got %0d expected 60", cap_busy);
    else passed++;
    total++;
    if (cap_hold_err != 0) $display("FAIL op0_data_stable_high: got %0d changes expected 0", cap_hold_err);
    else passed++;
    total++;
    if (ack_toggle !== ~ack0) $display("FAIL op0_ack: got %b expected %b", ack_toggle, ~ack0);
    else passed++;
  endtask

  task automatic test_frame_op5();
    kick(4'd5, 32'hFFFF_FFFF);
    capture(0, '0, '0, 0, '0);
    total++;
    if (cap_timeout || cap_rises != 4 || cap_bits !== 14'b0101) $display("FAIL op5_frame: rises %0d bits %b expected 4 / 0101", cap_rises, cap_bits);
    else passed++;
    total++;
    if (cap_busy != 20) $display("FAIL op5_busy_len: got %0d expected 20", cap_busy);
    else passed++;
    total++;
    if (data_out !== 1'b0 || clock_out !== 1'b0) $display("FAIL op5_idle_lines: got %b%b expected 00", data_out, clock_out);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic        ack0;
    logic [31:0] c2;
    ack0 = ack_toggle;
    kick(4'd0, 32'h0000_00F0);
    c2 = {cmd_in[31:5], 4'd9, ~cmd_in[0]};
    capture(10, c2, 32'h0000_03FF, 0, '0);
    total++;
    if (cap_timeout || cap_rises != 14 || cap_bits !== 14'h00F0) $display("FAIL b2b_first_frame: rises %0d bits %h expected 14 / 00f0", cap_rises, cap_bits);
    else passed++;
    capture(0, '0, '0, 0, '0);
    total++;
    if (cap_timeout || cap_wait != 0) $display("FAIL b2b_gapless_start: wait %0d timeout %b expected 0/0", cap_wait, cap_timeout);
    else passed++;
    total++;
    if (cap_rises != 4 || cap_bits !== 14'h0009 || cap_busy != 20) $display("FAIL b2b_second_frame: rises %0d bits %h busy %0d expected 4 / 0009 / 20", cap_rises, cap_bits, cap_busy);
    else passed++;
    total++;
    if (ack_toggle !== ack0) $display("FAIL b2b_ack: got %b expected %b", ack_toggle, ack0);
    else passed++;
  endtask

  task automatic test_coalesce();
    logic        ack0;
    logic [31:0] c1, c2;
    int          extra;
    ack0 = ack_toggle;
    kick(4'd2, 32'h0000_0123);
    c2 = cmd_in;
    c1 = {cmd_in[31:5], 4'd7, ~cmd_in[0]};
    capture(5, c1, 32'h0000_0321, 15, c2);
    total++;
    if (cap_timeout || cap_rises != 4 || cap_bits !== 14'h0002) $display("FAIL coalesce_frame: rises %0d bits %h expected 4 / 0002", cap_rises, cap_bits);
    else passed++;
    extra = 0;
    repeat (12) begin
      @(negedge clock);
      if (busy) extra++;
    end
    total++;
    if (extra != 0) $display("FAIL coalesce_no_second: busy cycles %0d expected 0", extra);
    else passed++;
    total++;
    if (ack_toggle !== ~ack0) $display("FAIL coalesce_ack_once: got %b expected %b", ack_toggle, ~ack0);
    else passed++;
  endtask

  task automatic test_all_opcodes();
    logic [3:0]  op;
    logic [9:0]  pl;
    logic [13:0] exp_bits;
    int          exp_rises;
    for (int i = 0; i < 64 + 15; i++) begin
      op = (i < 16) ? 4'(i) : 4'd0;
      pl = 10'($urandom);
      kick(op, {22'($urandom), pl});
      capture(0, '0, '0, 0, '0);
      exp_rises = (op == 4'd0) ? 14 : 4;
      exp_bits  = (op == 4'd0) ? {op, pl} : {10'd0, op};
      total++;
      if (cap_timeout || cap_rises != exp_rises || cap_bits !== exp_bits)
        $display("FAIL deser_op%0d: rises %0d bits %h expected %0d / %h", op, cap_rises, cap_bits, exp_rises, exp_bits);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_reset_midframe();
    test_frame_op0();
    test_frame_op5();
    test_back_to_back();
    test_coalesce();
    test_all_opcodes();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
